// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 timing constants and vertical phase encoding
// Purpose: shared H/V timing constants, derived totals, window bounds and the
//          vertical-phase state encoding for vga_sync_gen and v_phase_fsm.
// Ports:   none (package).
package vga_timing_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;

  // Line counts carry a _LINES suffix so they do not collide with the
  // V_FP / V_BP phase names below.
  localparam int V_ACTIVE     = 480;
  localparam int V_FP_LINES   = 10;
  localparam int V_SYNC_LINES = 2;
  localparam int V_BP_LINES   = 33;
  localparam int V_TOTAL      = V_ACTIVE + V_FP_LINES + V_SYNC_LINES + V_BP_LINES;

  // 10-bit window bounds, folded at elaboration time.
  localparam logic [9:0] H_VIS_END    = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);

  localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FP_LINES);
  localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FP_LINES + V_SYNC_LINES);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);

  localparam logic SYNC_POL_DEFAULT = 1'b0;

  typedef enum logic [1:0] {
    V_ACT = 2'd0,
    V_FP  = 2'd1,
    V_SYN = 2'd2,
    V_BP  = 2'd3
  } v_phase_t;

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - horizontal-counter input and sync/pixel output bundle
// Purpose: groups the vertical stage's inputs and outputs.
// Ports:   h_count/trig_v from the horizontal counter (master drives);
//          v_count, hsync, vsync, video_on, pix_x, pix_y, frame_start,
//          sync_err from the vertical stage (slave drives).
interface vga_sync_gen_if;

  logic [9:0] h_count;
  logic       trig_v;
  logic [9:0] v_count;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       frame_start;
  logic       sync_err;

  modport master (
    output h_count, trig_v,
    input  v_count, hsync, vsync, video_on, pix_x, pix_y, frame_start, sync_err
  );

  modport slave (
    input  h_count, trig_v,
    output v_count, hsync, vsync, video_on, pix_x, pix_y, frame_start, sync_err
  );

endinterface

// File: rtl/vga_sync_gen_v_phase_fsm.sv
// rtl/vga_sync_gen_v_phase_fsm.sv - vertical line counter and phase FSM
// Purpose: holds the 0..524 line count and the vertical phase; both step only
//          on trig_v. Exposes next-line values so the top can register its
//          outputs aligned with the incoming h_count.
// Ports:   clk, rst_n (async active-low), trig_v in;
//          v_count (registered line), v_next (line after this cycle),
//          active_next / sync_next (phase after this cycle is V_ACT / V_SYN).
module v_phase_fsm
  import vga_timing_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trig_v,
  output logic [9:0] v_count,
  output logic [9:0] v_next,
  output logic       active_next,
  output logic       sync_next
);

  v_phase_t state;
  v_phase_t state_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= V_ACT;
      v_count <= '0;
    end else begin
      state   <= state_next;
      v_count <= v_next;
    end
  end

  // Phase moves only when the new line lands on a region boundary, so the
  // state is always consistent with the line count it accompanies.
  always_comb begin
    v_next     = v_count;
    state_next = state;
    if (trig_v) begin
      v_next = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
      case (state)
        V_ACT:   if (v_next == V_FP_START)   state_next = V_FP;
        V_FP:    if (v_next == V_SYNC_START) state_next = V_SYN;
        V_SYN:   if (v_next == V_BP_START)   state_next = V_BP;
        V_BP:    if (v_next == 10'd0)        state_next = V_ACT;
        default:                             state_next = V_ACT;
      endcase
    end
  end

  always_comb begin
    active_next = (state_next == V_ACT);
    sync_next   = (state_next == V_SYN);
  end

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - vertical stage: line count, sync, video window, pixel coords
// Purpose: consumes h_count/trig_v from the horizontal counter and produces
//          registered hsync/vsync, video_on, pix_x/pix_y, frame_start and a
//          sticky sync_err, all one clock after the h_count they describe.
// Ports:   clk, rst_n (async active-low); bus (slave) carrying h_count,
//          trig_v in and v_count, hsync, vsync, video_on, pix_x, pix_y,
//          frame_start, sync_err out.
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter logic SYNC_POL = SYNC_POL_DEFAULT
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.slave  bus
);

  logic [9:0] v_count;
  logic [9:0] v_next;
  logic       active_next;
  logic       sync_next;

  v_phase_fsm u_v_phase_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .trig_v      (bus.trig_v),
    .v_count     (v_count),
    .v_next      (v_next),
    .active_next (active_next),
    .sync_next   (sync_next)
  );

  logic h_illegal;
  logic h_in_sync;
  logic von_next;
  logic trig_misaligned;

  // An out-of-range h_count falls outside both the visible and sync windows,
  // so it naturally yields video_on=0 and an inactive hsync.
  always_comb begin
    h_illegal       = (bus.h_count > H_LAST);
    h_in_sync       = (bus.h_count >= H_SYNC_START) && (bus.h_count <= H_SYNC_END);
    von_next        = (bus.h_count < H_VIS_END) && active_next;
    trig_misaligned = bus.trig_v && (bus.h_count != 10'd0);
  end

  logic       hsync_q;
  logic       vsync_q;
  logic       video_on_q;
  logic [9:0] pix_x_q;
  logic [9:0] pix_y_q;
  logic       frame_start_q;
  logic       sync_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      hsync_q       <= h_in_sync ? SYNC_POL : ~SYNC_POL;
      vsync_q       <= sync_next ? SYNC_POL : ~SYNC_POL;
      video_on_q    <= von_next;
      pix_x_q       <= von_next ? bus.h_count : 10'd0;
      pix_y_q       <= von_next ? v_next : 10'd0;
      frame_start_q <= bus.trig_v && (v_count == V_LAST);
      sync_err_q    <= sync_err_q | h_illegal | trig_misaligned;
    end
  end

  assign bus.v_count     = v_count;
  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.video_on    = video_on_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.frame_start = frame_start_q;
  assign bus.sync_err    = sync_err_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - self-checking bench for vga_sync_gen
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cnt_von, cnt_hs, cnt_vs, cnt_fs;
  int   m_v;
  bit   m_err;

  typedef struct packed {
    logic [9:0] v;
    logic       hs;
    logic       vs;
    logic       von;
    logic [9:0] px;
    logic [9:0] py;
    logic       fs;
    logic       err;
  } obs_t;

  typedef struct {
    int   h;
    logic von;
    logic hs;
    int   px;
    int   py;
  } vec_t;

  obs_t sb[$];
  vec_t vecs[8];

  vga_sync_gen_if bus();

  vga_sync_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #20 clk = ~clk;

  initial begin
    #(40 * 200000);
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic obs_t sample();
    obs_t o;
    o.v   = bus.v_count;
    o.hs  = bus.hsync;
    o.vs  = bus.vsync;
    o.von = bus.video_on;
    o.px  = bus.pix_x;
    o.py  = bus.pix_y;
    o.fs  = bus.frame_start;
    o.err = bus.sync_err;
    return o;
  endfunction

  task automatic compare(input string name, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got v=%0d hs=%b vs=%b von=%b px=%0d py=%0d fs=%b err=%b, want v=%0d hs=%b vs=%b von=%b px=%0d py=%0d fs=%b err=%b",
               name, got.v, got.hs, got.vs, got.von, got.px, got.py, got.fs, got.err,
               want.v, want.hs, want.vs, want.von, want.px, want.py, want.fs, want.err);
    end
  endtask

  task automatic check_val(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic zero_counts();
    cnt_von = 0;
    cnt_hs  = 0;
    cnt_vs  = 0;
    cnt_fs  = 0;
  endtask

  // Drive one cycle, predict its registered outputs from line-range rules,
  // then pop and compare once the DUT has clocked them out.
  task automatic drive(input string name, input int h, input bit t);
    obs_t e;
    obs_t got;
    int   nv;
    bus.h_count = 10'(h);
    bus.trig_v  = t;
    nv = t ? ((m_v == 524) ? 0 : m_v + 1) : m_v;
    if ((t && h != 0) || h > 799) m_err = 1'b1;
    e.v   = 10'(nv);
    e.von = (h < 640) && (nv < 480);
    e.hs  = !(h >= 656 && h <= 751);
    e.vs  = !(nv == 490 || nv == 491);
    e.px  = e.von ? 10'(h) : 10'd0;
    e.py  = e.von ? 10'(nv) : 10'd0;
    e.fs  = t && (m_v == 524);
    e.err = m_err;
    sb.push_back(e);
    m_v = nv;
    @(posedge clk);
    #1;
    got = sample();
    compare(name, got, sb.pop_front());
    if (got.von) cnt_von++;
    if (!got.hs) cnt_hs++;
    if (!got.vs) cnt_vs++;
    if (got.fs)  cnt_fs++;
  endtask

  task automatic run_lines(input string name, input int n);
    for (int l = 0; l < n; l++)
      for (int h = 0; h < 800; h++)
        drive(name, h, h == 0);
  endtask

  // Fast line advance: trig_v with h_count==0 every cycle is legal input.
  task automatic ff(input int target);
    for (int i = 0; i < 1100 && m_v != target; i++)
      drive("ff", 0, 1'b1);
    check_val("ff_reached", m_v, target);
  endtask

  task automatic do_reset();
    obs_t rst_obs;
    rst_obs = '{v: 10'd0, hs: 1'b1, vs: 1'b1, von: 1'b0, px: 10'd0, py: 10'd0, fs: 1'b0, err: 1'b0};
    rst_n = 1'b0;
    #1;
    compare("reset_values", sample(), rst_obs);
    m_v   = 0;
    m_err = 1'b0;
    sb.delete();
    bus.h_count = 10'd0;
    bus.trig_v  = 1'b0;
    repeat (2) @(posedge clk);
    #5 rst_n = 1'b1;
  endtask

  initial begin
    vecs[0] = '{h: 0,   von: 1'b1, hs: 1'b1, px: 0,   py: 100};
    vecs[1] = '{h: 639, von: 1'b1, hs: 1'b1, px: 639, py: 100};
    vecs[2] = '{h: 640, von: 1'b0, hs: 1'b1, px: 0,   py: 0};
    vecs[3] = '{h: 655, von: 1'b0, hs: 1'b1, px: 0,   py: 0};
    vecs[4] = '{h: 656, von: 1'b0, hs: 1'b0, px: 0,   py: 0};
    vecs[5] = '{h: 751, von: 1'b0, hs: 1'b0, px: 0,   py: 0};
    vecs[6] = '{h: 752, von: 1'b0, hs: 1'b1, px: 0,   py: 0};
    vecs[7] = '{h: 799, von: 1'b0, hs: 1'b1, px: 0,   py: 0};

    bus.h_count = 10'd0;
    bus.trig_v  = 1'b0;
    zero_counts();
    #3;
    do_reset();

    // Upstream already past h=0 of line 0: 800 clocks later line 1 begins.
    for (int h = 1; h < 800; h++) drive("line0", h, 1'b0);
    drive("line0", 0, 1'b1);
    check_val("after_800_clks_v", bus.v_count, 1);

    // Line 100 in full.
    ff(99);
    zero_counts();
    run_lines("line100", 1);
    check_val("line100_video_clks", cnt_von, 640);
    check_val("line100_hsync_clks", cnt_hs, 96);
    check_val("line100_v", bus.v_count, 100);

    // Horizontal window edges on line 100.
    for (int i = 0; i < 8; i++) begin
      bus.h_count = 10'(vecs[i].h);
      bus.trig_v  = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (bus.video_on !== vecs[i].von || bus.hsync !== vecs[i].hs ||
          bus.pix_x != 10'(vecs[i].px) || bus.pix_y != 10'(vecs[i].py) || bus.sync_err !== 1'b0) begin
        errors++;
        $display("FAIL hedge h=%0d: got von=%b hs=%b px=%0d py=%0d err=%b, want von=%b hs=%b px=%0d py=%0d err=0",
                 vecs[i].h, bus.video_on, bus.hsync, bus.pix_x, bus.pix_y, bus.sync_err,
                 vecs[i].von, vecs[i].hs, vecs[i].px, vecs[i].py);
      end
    end

    // Lines 489..492 in full: vsync low exactly on 490..491, no video.
    ff(488);
    zero_counts();
    run_lines("vsync_lines", 4);
    check_val("vsync_low_clks", cnt_vs, 1600);
    check_val("video_in_blank", cnt_von, 0);

    // Wrap into line 0, then one whole frame at one clock per line.
    ff(0);
    zero_counts();
    drive("frame", 0, 1'b1);
    ff(0);
    check_val("frame_start_count", cnt_fs, 1);
    check_val("frame_vsync_lines", cnt_vs, 2);
    check_val("frame_video_lines", cnt_von, 480);

    // Reset in the middle of line 491 (vsync asserted).
    ff(491);
    for (int h = 1; h <= 400; h++) drive("line491", h, 1'b0);
    do_reset();
    zero_counts();
    ff(489);
    check_val("no_vsync_after_reset", cnt_vs, 0);
    check_val("no_fs_after_reset", cnt_fs, 0);
    drive("to490", 0, 1'b1);
    check_val("vsync_resumes", bus.vsync, 0);

    // Misaligned trig_v still advances the line and latches sync_err.
    for (int h = 1; h < 300; h++) drive("pre_inject", h, 1'b0);
    drive("inject", 300, 1'b1);
    check_val("inject_v", bus.v_count, 491);
    check_val("inject_err", bus.sync_err, 1);
    for (int h = 301; h <= 320; h++) drive("post_inject", h, 1'b0);
    check_val("err_sticky", bus.sync_err, 1);

    // Illegal h_count from a clean state.
    do_reset();
    drive("illegal_h", 900, 1'b0);
    check_val("illegal_video_on", bus.video_on, 0);
    check_val("illegal_hsync", bus.hsync, 1);
    check_val("illegal_err", bus.sync_err, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
